// File: rtl/rle_decode_low_area.sv
// Run-length decoder: reads {byte,count} pairs from the dpsram and writes expanded plaintext back, 4 bytes per word.
// Optional RLE_DEC_LIMIT_EN adds max_size/overflow to cap the plaintext length.
module rle_decode_low_area #(
    parameter int unsigned ADDR_W = 16,
    parameter int unsigned SIZE_W = 32
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              start,
    input  logic [31:0]       rle_addr,
    input  logic [SIZE_W-1:0] rle_size,
    input  logic [31:0]       message_addr,
`ifdef RLE_DEC_LIMIT_EN
    input  logic [SIZE_W-1:0] max_size,
    output logic              overflow,
`endif
    output logic [SIZE_W-1:0] message_size,
    output logic              done,
    output logic              port_A_clk,
    output logic [ADDR_W-1:0] port_A_addr,
    output logic              port_A_we,
    output logic [31:0]       port_A_data_in,
    input  logic [31:0]       port_A_data_out
);

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_RD   = 3'd1;
    localparam logic [2:0] S_WT   = 3'd2;
    localparam logic [2:0] S_EXP  = 3'd3;
    localparam logic [2:0] S_WR   = 3'd4;
    localparam logic [2:0] S_FL   = 3'd5;
    localparam logic [2:0] S_FW   = 3'd6;
    localparam logic [2:0] S_DONE = 3'd7;

    logic [2:0]        state, state_d;
    logic [ADDR_W-1:0] rd_ptr, rd_ptr_d, wr_ptr, wr_ptr_d, addr_d;
    logic [SIZE_W-1:0] rd_cnt, rd_cnt_d, size, size_d, msg_d;
    logic [31:0]       word, word_d, obuf, obuf_d, data_d;
    logic [7:0]        run, run_d, cur_byte;
    logic [1:0]        obuf_cnt, obuf_cnt_d;
    logic              pair, pair_d, we_d, done_d, keep, start_ok;
    logic              unused_addr_bits;

    assign port_A_clk       = clk;
    assign unused_addr_bits = ^{rle_addr[31:ADDR_W], message_addr[31:ADDR_W]};
    assign cur_byte         = pair ? word[31:24] : word[15:8];
    assign start_ok         = start && ((state == S_IDLE) || (state == S_DONE));

`ifdef RLE_DEC_LIMIT_EN
    logic ovf, ovf_d;

    // Sticky "bytes were dropped" flag, published on overflow together with done.
    always_comb begin
        ovf_d = ovf;
        if (start_ok) begin
            ovf_d = 1'b0;
        end else if ((state == S_EXP) && (run != 8'd0) && !keep) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            ovf      <= 1'b0;
            overflow <= 1'b0;
        end else begin
            ovf      <= ovf_d;
            overflow <= ovf_d && (state_d == S_DONE);
        end
    end

    assign keep = (message_size != max_size);
`else
    assign keep = 1'b1;
`endif

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state;
        rd_ptr_d   = rd_ptr;
        wr_ptr_d   = wr_ptr;
        rd_cnt_d   = rd_cnt;
        size_d     = size;
        word_d     = word;
        run_d      = run;
        pair_d     = pair;
        obuf_d     = obuf;
        obuf_cnt_d = obuf_cnt;
        msg_d      = message_size;
        done_d     = done;
        addr_d     = port_A_addr;
        data_d     = port_A_data_in;
        we_d       = 1'b0;
        case (state)
            S_IDLE, S_DONE: begin
                if (start) begin
                    done_d     = 1'b0;
                    msg_d      = '0;
                    rd_ptr_d   = rle_addr[ADDR_W-1:0];
                    wr_ptr_d   = message_addr[ADDR_W-1:0];
                    addr_d     = rle_addr[ADDR_W-1:0];
                    size_d     = rle_size;
                    rd_cnt_d   = '0;
                    obuf_d     = '0;
                    obuf_cnt_d = 2'd0;
                    state_d    = (rle_size == '0) ? S_FL : S_RD;
                end
            end
            S_RD: state_d = S_WT;
            S_WT: begin
                word_d  = port_A_data_out;
                run_d   = port_A_data_out[7:0];
                pair_d  = 1'b0;
                state_d = S_EXP;
            end
            S_EXP: begin
                if (run == 8'd0) begin
                    if (!pair) begin
                        pair_d = 1'b1;
                        run_d  = word[23:16];
                    end else begin
                        rd_ptr_d = rd_ptr + ADDR_W'(4);
                        rd_cnt_d = rd_cnt + SIZE_W'(4);
                        addr_d   = rd_ptr_d;
                        state_d  = (rd_cnt_d >= size) ? S_FL : S_RD;
                    end
                end else begin
                    run_d = run - 8'd1;
                    if (keep) begin
                        obuf_d[{obuf_cnt, 3'b000} +: 8] = cur_byte;
                        msg_d = message_size + SIZE_W'(1);
                        // Fourth byte completes the word: write it out, then resume the run.
                        if (obuf_cnt == 2'd3) begin
                            we_d       = 1'b1;
                            addr_d     = wr_ptr;
                            data_d     = obuf_d;
                            obuf_d     = '0;
                            obuf_cnt_d = 2'd0;
                            state_d    = S_WR;
                        end else begin
                            obuf_cnt_d = obuf_cnt + 2'd1;
                        end
                    end
                end
            end
            S_WR: begin
                wr_ptr_d = wr_ptr + ADDR_W'(4);
                state_d  = S_EXP;
            end
            S_FL: begin
                if (obuf_cnt != 2'd0) begin
                    we_d       = 1'b1;
                    addr_d     = wr_ptr;
                    data_d     = obuf;
                    obuf_d     = '0;
                    obuf_cnt_d = 2'd0;
                    state_d    = S_FW;
                end else begin
                    done_d  = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_FW: begin
                wr_ptr_d = wr_ptr + ADDR_W'(4);
                done_d   = 1'b1;
                state_d  = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state          <= S_IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            rd_cnt         <= '0;
            size           <= '0;
            word           <= '0;
            run            <= '0;
            pair           <= 1'b0;
            obuf           <= '0;
            obuf_cnt       <= 2'd0;
            message_size   <= '0;
            done           <= 1'b0;
            port_A_addr    <= '0;
            port_A_we      <= 1'b0;
            port_A_data_in <= '0;
        end else begin
            state          <= state_d;
            rd_ptr         <= rd_ptr_d;
            wr_ptr         <= wr_ptr_d;
            rd_cnt         <= rd_cnt_d;
            size           <= size_d;
            word           <= word_d;
            run            <= run_d;
            pair           <= pair_d;
            obuf           <= obuf_d;
            obuf_cnt       <= obuf_cnt_d;
            message_size   <= msg_d;
            done           <= done_d;
            port_A_addr    <= addr_d;
            port_A_we      <= we_d;
            port_A_data_in <= data_d;
        end
    end

endmodule

// File: tb/tb_rle_decode_low_area.sv
// Scoreboard bench for rle_decode_low_area: expected plaintext writes are queued at stimulus time and compared after done.
module tb_rle_decode_low_area;

    logic        clk = 1'b0;
    logic        nreset;
    logic        start;
    logic [31:0] rle_addr, message_addr, rle_size;
    logic [31:0] message_size;
    logic        done, port_A_clk, port_A_we;
    logic [15:0] port_A_addr;
    logic [31:0] port_A_data_in, port_A_data_out;
`ifdef RLE_DEC_LIMIT_EN
    logic [31:0] max_size;
    logic        overflow;
`endif

    logic [31:0] mem [0:16383];
    logic [47:0] exp_q[$];
    logic [47:0] got_q[$];
    logic [47:0] e, g;
    int          n_checks, n_fail, we_cnt;
    bit          ok;

    always #5 clk = ~clk;

    rle_decode_low_area dut (
        .clk(clk), .nreset(nreset), .start(start), .rle_addr(rle_addr), .rle_size(rle_size),
        .message_addr(message_addr),
`ifdef RLE_DEC_LIMIT_EN
        .max_size(max_size), .overflow(overflow),
`endif
        .message_size(message_size), .done(done), .port_A_clk(port_A_clk), .port_A_addr(port_A_addr),
        .port_A_we(port_A_we), .port_A_data_in(port_A_data_in), .port_A_data_out(port_A_data_out)
    );

    // Synchronous dpsram model: read data valid the cycle after the address.
    always @(posedge clk) begin
        if (port_A_we) mem[port_A_addr[15:2]] <= port_A_data_in;
        port_A_data_out <= mem[port_A_addr[15:2]];
    end

    always @(negedge clk) begin
        if (nreset && port_A_we) begin
            got_q.push_back({port_A_addr, port_A_data_in});
            we_cnt++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    function automatic logic [31:0] pk(input logic [7:0] c0, input logic [7:0] b0,
                                       input logic [7:0] c1, input logic [7:0] b1);
        return {b1, c1, b0, c0};
    endfunction

    task automatic kick(input logic [31:0] ra, input logic [31:0] rs, input logic [31:0] ma);
        rle_addr = ra; rle_size = rs; message_addr = ma;
        @(negedge clk) start = 1'b1;
        @(negedge clk) start = 1'b0;
    endtask

    task automatic wait_done(input int max_cyc, output bit fin);
        fin = 1'b0;
        for (int i = 0; i < max_cyc; i++) begin
            if (done) begin fin = 1'b1; break; end
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        nreset = 1'b0;
        repeat (2) @(negedge clk);
        n_checks += 5;
        if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done got %b expected 0", done); end
        if (message_size !== 32'd0) begin n_fail++; $display("FAIL reset_size got %0d expected 0", message_size); end
        if (port_A_we !== 1'b0) begin n_fail++; $display("FAIL reset_we got %b expected 0", port_A_we); end
        if (port_A_addr !== 16'd0) begin n_fail++; $display("FAIL reset_addr got %h expected 0", port_A_addr); end
        if (port_A_data_in !== 32'd0) begin n_fail++; $display("FAIL reset_data got %h expected 0", port_A_data_in); end
        nreset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_single_run;
        mem[16'h0100 >> 2] <= pk(8'd3, 8'h41, 8'd0, 8'h00);
        exp_q.push_back({16'h1000, 32'h0041_4141});
        kick(32'h0100, 32'd4, 32'h1000);
        wait_done(200, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL t1_done timeout got 0 expected 1"); end
        if (message_size !== 32'd3) begin n_fail++; $display("FAIL t1_size got %0d expected 3", message_size); end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL t1_write_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL t1_write got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_two_pairs;
        mem[16'h0100 >> 2] <= pk(8'd2, 8'h41, 8'd2, 8'h42);
        exp_q.push_back({16'h1000, 32'h4242_4141});
        kick(32'h0100, 32'd4, 32'h1000);
        wait_done(200, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL t2_done timeout got 0 expected 1"); end
        if (message_size !== 32'd4) begin n_fail++; $display("FAIL t2_size got %0d expected 4", message_size); end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL t2_write_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL t2_write got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // Long run crossing many word boundaries, with a start pulse while busy that must be ignored.
    task automatic test_long_run;
        mem[16'h0100 >> 2] <= pk(8'd255, 8'h5A, 8'd0, 8'h00);
        for (int i = 0; i < 63; i++) exp_q.push_back({16'(16'h1000 + 4 * i), 32'h5A5A_5A5A});
        exp_q.push_back({16'(16'h1000 + 4 * 63), 32'h005A_5A5A});
        kick(32'h0100, 32'd4, 32'h1000);
        repeat (30) @(negedge clk);
        rle_size = 32'd0; start = 1'b1;
        @(negedge clk) start = 1'b0;
        wait_done(1000, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL t3_done timeout got 0 expected 1"); end
        if (message_size !== 32'd255) begin n_fail++; $display("FAIL t3_size got %0d expected 255", message_size); end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL t3_write_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL t3_write got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    task automatic test_empty;
        int w0;
        w0 = we_cnt;
        kick(32'h0100, 32'd0, 32'h1000);
        n_checks++;
        if (done !== 1'b0) begin n_fail++; $display("FAIL t4_done_early got %b expected 0", done); end
        @(negedge clk);
        n_checks += 3;
        if (done !== 1'b1) begin n_fail++; $display("FAIL t4_done got %b expected 1", done); end
        if (message_size !== 32'd0) begin n_fail++; $display("FAIL t4_size got %0d expected 0", message_size); end
        if (we_cnt !== w0) begin n_fail++; $display("FAIL t4_writes got %0d expected %0d", we_cnt - w0, 0); end
    endtask

    task automatic test_reset_mid_frame;
        mem[16'h0100 >> 2] <= pk(8'd255, 8'h5A, 8'd0, 8'h00);
        kick(32'h0100, 32'd4, 32'h1000);
        for (int i = 0; i < 300 && got_q.size() < 5; i++) @(negedge clk);
        n_checks++;
        if (got_q.size() < 5) begin n_fail++; $display("FAIL t5_progress got %0d writes expected 5", got_q.size()); end
        #2 nreset = 1'b0;
        #1;
        n_checks += 4;
        if (done !== 1'b0) begin n_fail++; $display("FAIL t5_done got %b expected 0", done); end
        if (message_size !== 32'd0) begin n_fail++; $display("FAIL t5_size got %0d expected 0", message_size); end
        if (port_A_we !== 1'b0) begin n_fail++; $display("FAIL t5_we got %b expected 0", port_A_we); end
        if (port_A_data_in !== 32'd0) begin n_fail++; $display("FAIL t5_data got %h expected 0", port_A_data_in); end
        @(negedge clk) nreset = 1'b1;
        @(negedge clk);
        got_q.delete(); exp_q.delete();
        test_single_run();
    endtask

    // Restart straight from DONE; second frame has a leading pad pair and spans two input words.
    task automatic test_back_to_back;
        mem[16'h0300 >> 2] <= pk(8'd0, 8'h00, 8'd1, 8'h43);
        mem[16'h0304 >> 2] <= pk(8'd5, 8'h44, 8'd0, 8'h00);
        exp_q.push_back({16'h3000, 32'h4444_4443});
        exp_q.push_back({16'h3004, 32'h0000_4444});
        n_checks++;
        if (done !== 1'b1) begin n_fail++; $display("FAIL b2b_pre_done got %b expected 1", done); end
        kick(32'h0300, 32'd8, 32'h3000);
        n_checks += 2;
        if (done !== 1'b0) begin n_fail++; $display("FAIL b2b_clear_done got %b expected 0", done); end
        if (message_size !== 32'd0) begin n_fail++; $display("FAIL b2b_clear_size got %0d expected 0", message_size); end
        wait_done(300, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL b2b_done timeout got 0 expected 1"); end
        if (message_size !== 32'd6) begin n_fail++; $display("FAIL b2b_size got %0d expected 6", message_size); end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL b2b_write_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL b2b_write got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

    // Encode random bytes with a reference RLE encoder, decode, and compare against the originals.
    task automatic test_round_trip;
        logic [7:0]  src [16];
        logic [15:0] pq[$];
        logic [7:0]  cb, cc;
        int          nw;
        for (int i = 0; i < 16; i++) src[i] = 8'(8'h61 + $urandom_range(0, 2));
        cb = src[0]; cc = 8'd1;
        for (int i = 1; i < 16; i++) begin
            if (src[i] == cb) cc = cc + 8'd1;
            else begin pq.push_back({cb, cc}); cb = src[i]; cc = 8'd1; end
        end
        pq.push_back({cb, cc});
        if (pq.size() % 2 == 1) pq.push_back(16'h0000);
        nw = pq.size() / 2;
        for (int i = 0; i < nw; i++) mem[(16'h0400 >> 2) + i] <= {pq[2 * i + 1], pq[2 * i]};
        for (int i = 0; i < 4; i++)
            exp_q.push_back({16'(16'h4000 + 4 * i), src[4 * i + 3], src[4 * i + 2], src[4 * i + 1], src[4 * i]});
        kick(32'h0400, 32'(4 * nw), 32'h4000);
        wait_done(500, ok);
        n_checks += 2;
        if (!ok) begin n_fail++; $display("FAIL t6_done timeout got 0 expected 1"); end
        if (message_size !== 32'd16) begin n_fail++; $display("FAIL t6_size got %0d expected 16", message_size); end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL t6_write_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL t6_write got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
    endtask

`ifdef RLE_DEC_LIMIT_EN
    task automatic test_limit;
        max_size = 32'd2;
        mem[16'h0100 >> 2] <= pk(8'd3, 8'h41, 8'd0, 8'h00);
        exp_q.push_back({16'h1000, 32'h0000_4141});
        kick(32'h0100, 32'd4, 32'h1000);
        wait_done(200, ok);
        n_checks += 3;
        if (!ok) begin n_fail++; $display("FAIL lim_done timeout got 0 expected 1"); end
        if (message_size !== 32'd2) begin n_fail++; $display("FAIL lim_size got %0d expected 2", message_size); end
        if (overflow !== 1'b1) begin n_fail++; $display("FAIL lim_overflow got %b expected 1", overflow); end
        n_checks++;
        if (got_q.size() !== exp_q.size()) begin n_fail++; $display("FAIL lim_write_count got %0d expected %0d", got_q.size(), exp_q.size()); end
        while (exp_q.size() > 0 && got_q.size() > 0) begin
            e = exp_q.pop_front(); g = got_q.pop_front(); n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL lim_write got %h expected %h", g, e); end
        end
        exp_q.delete(); got_q.delete();
        max_size = 32'hFFFF_FFFF;
    endtask
`endif

    initial begin
        n_checks = 0; n_fail = 0; we_cnt = 0;
        nreset = 1'b0; start = 1'b0;
        rle_addr = '0; rle_size = '0; message_addr = '0;
`ifdef RLE_DEC_LIMIT_EN
        max_size = 32'hFFFF_FFFF;
`endif
        for (int i = 0; i < 16384; i++) mem[i] <= 32'd0;
        test_reset();
        test_single_run();
        test_two_pairs();
        test_long_run();
        test_empty();
        test_reset_mid_frame();
        test_back_to_back();
        test_round_trip();
`ifdef RLE_DEC_LIMIT_EN
        test_limit();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
